// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM bank.
package pwm_pkg;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    localparam int DUTY_W = 8;
    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_bank_if.sv
// Control/output bundle between the register front end and the PWM bank.
interface pwm_bank_if #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
);
    logic                      en;
    logic                      load;
    logic                      mode;
    logic [PRESCALE_W-1:0]     prescale;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       out;
    logic                      period_start;

    modport master (
        output en, load, mode, prescale, period, duty,
        input  out, period_start
    );

    modport slave (
        input  en, load, mode, prescale, period, duty,
        output out, period_start
    );
endinterface

// File: rtl/pwm_channel.sv
// One PWM output: shadow/active duty pair, compare against the next counter
// value, and the registered output.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             boundary_i,
    input  logic             pending_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             out_o
);
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             out_q, out_d;

    always_comb begin
        shadow_d = load_i ? duty_i : shadow_q;
        active_d = active_q;
        // A load landing on the boundary bypasses the shadow stage.
        if (boundary_i) begin
            if (load_i)
                active_d = duty_i;
            else if (pending_i)
                active_d = shadow_q;
        end
        out_d = run_i && (cnt_i < active_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            out_q    <= out_d;
        end
    end

    assign out_o = out_q;
endmodule

// File: rtl/pwm_bank.sv
// Shared prescaler/counter timebase with edge or center alignment and
// period-boundary shadow updates, driving CHANNELS compare channels.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input logic       clk,
    input logic       rst,
    pwm_bank_if.slave bus
);
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    dir_e                  dir_q, dir_d;
    logic                  running_q, running_d;
    logic                  pending_q, pending_d;
    logic                  pstart_q, pstart_d;

    logic                  act_mode_q, act_mode_d;
    logic [PRESCALE_W-1:0] act_presc_q, act_presc_d;
    logic [WIDTH-1:0]      act_period_q, act_period_d;
    logic                  sh_mode_q, sh_mode_d;
    logic [PRESCALE_W-1:0] sh_presc_q, sh_presc_d;
    logic [WIDTH-1:0]      sh_period_q, sh_period_d;

    logic                  tick;
    logic                  wrap;
    logic                  boundary;
    logic [CHANNELS-1:0]   out_w;

    assign tick = bus.en && (presc_q == act_presc_q);

    // The first tick after enable always opens a fresh period.
    assign wrap = !running_q ||
                  ((act_mode_q == PWM_EDGE) ? (cnt_q == act_period_q)
                                            : (dir_q == DIR_DOWN && cnt_q == '0));
    assign boundary = tick && wrap;

    always_comb begin
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        running_d    = running_q;
        pending_d    = pending_q;
        act_mode_d   = act_mode_q;
        act_presc_d  = act_presc_q;
        act_period_d = act_period_q;
        sh_mode_d    = sh_mode_q;
        sh_presc_d   = sh_presc_q;
        sh_period_d  = sh_period_q;
        pstart_d     = boundary;

        if (bus.load) begin
            sh_mode_d   = bus.mode;
            sh_presc_d  = bus.prescale;
            sh_period_d = bus.period;
            pending_d   = 1'b1;
        end

        if (!bus.en) begin
            presc_d   = '0;
            cnt_d     = '0;
            dir_d     = DIR_UP;
            running_d = 1'b0;
        end else if (tick) begin
            presc_d   = '0;
            running_d = 1'b1;
            if (boundary) begin
                cnt_d     = '0;
                dir_d     = DIR_UP;
                pending_d = 1'b0;
                if (bus.load) begin
                    act_mode_d   = bus.mode;
                    act_presc_d  = bus.prescale;
                    act_period_d = bus.period;
                end else if (pending_q) begin
                    act_mode_d   = sh_mode_q;
                    act_presc_d  = sh_presc_q;
                    act_period_d = sh_period_q;
                end
            end else if (act_mode_q == PWM_EDGE) begin
                cnt_d = cnt_q + 1'b1;
            end else if (dir_q == DIR_UP) begin
                // The top value is held for a second tick while turning around.
                if (cnt_q == act_period_q)
                    dir_d = DIR_DOWN;
                else
                    cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            running_q    <= 1'b0;
            pending_q    <= 1'b0;
            pstart_q     <= 1'b0;
            act_mode_q   <= PWM_EDGE;
            act_presc_q  <= '0;
            act_period_q <= '0;
            sh_mode_q    <= PWM_EDGE;
            sh_presc_q   <= '0;
            sh_period_q  <= '0;
        end else begin
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            running_q    <= running_d;
            pending_q    <= pending_d;
            pstart_q     <= pstart_d;
            act_mode_q   <= act_mode_d;
            act_presc_q  <= act_presc_d;
            act_period_q <= act_period_d;
            sh_mode_q    <= sh_mode_d;
            sh_presc_q   <= sh_presc_d;
            sh_period_q  <= sh_period_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load_i    (bus.load),
            .duty_i    (bus.duty[gi*WIDTH +: WIDTH]),
            .boundary_i(boundary),
            .pending_i (pending_q),
            .run_i     (running_d),
            .cnt_i     (cnt_d),
            .out_o     (out_w[gi])
        );
    end

    assign bus.out          = out_w;
    assign bus.period_start = pstart_q;
endmodule
